// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: constants and helpers shared by the rv32i issue stage and the ALU.
//   - Opcode constants (inst[6:0]) for the instruction classes the stage decodes.
//   - 4-bit ALU operation codes, identical to the encoding the `alu` consumes.
//   - Operand-select enums produced by alu_ctrl and consumed by alu_issue.
//   - arith_op(): funct3/funct7_5 -> ALU op for the register/immediate arithmetic groups.
package alu_issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_XOR  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'ha;
  localparam logic [3:0] ALU_SRL  = 4'hb;
  localparam logic [3:0] ALU_SRA  = 4'hc;

  // Source of the ALU x operand.
  typedef enum logic [1:0] {
    X_SEL_RS1  = 2'd0,
    X_SEL_PC   = 2'd1,
    X_SEL_ZERO = 2'd2
  } x_sel_e;

  // Source of the ALU y operand; FOUR produces the link value for jumps.
  typedef enum logic [1:0] {
    Y_SEL_RS2  = 2'd0,
    Y_SEL_IMM  = 2'd1,
    Y_SEL_FOUR = 2'd2,
    Y_SEL_ZERO = 2'd3
  } y_sel_e;

  // funct3 -> ALU op for R-type / OP-IMM. sub_ok is cleared for OP-IMM,
  // where funct7_5 is part of the immediate for addi and never means sub.
  function automatic logic [3:0] arith_op(input logic [2:0] funct3,
                                          input logic       funct7_5,
                                          input logic       sub_ok);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (sub_ok && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_ctrl: combinational decode of opcode/funct3/funct7_5 for the issue stage.
//   in : opcode[6:0], funct3[2:0], funct7_5
//   out: alu_op[3:0], x_sel, y_sel (operand source selects),
//        wen (class writes rd; rd==0 masking is done by the caller),
//        illegal (unsupported opcode or branch funct3 01x).
// Illegal encodings decode to add with zero operands and no writeback.
module alu_ctrl
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output x_sel_e     x_sel,
  output y_sel_e     y_sel,
  output logic       wen,
  output logic       illegal
);

  // Instruction-class decode; defaults describe the illegal case.
  always_comb begin
    alu_op  = ALU_ADD;
    x_sel   = X_SEL_ZERO;
    y_sel   = Y_SEL_ZERO;
    wen     = 1'b0;
    illegal = 1'b1;
    case (opcode)
      OP_R: begin
        alu_op  = arith_op(funct3, funct7_5, 1'b1);
        x_sel   = X_SEL_RS1;
        y_sel   = Y_SEL_RS2;
        wen     = 1'b1;
        illegal = 1'b0;
      end
      OP_IMM: begin
        alu_op  = arith_op(funct3, funct7_5, 1'b0);
        x_sel   = X_SEL_RS1;
        y_sel   = Y_SEL_IMM;
        wen     = 1'b1;
        illegal = 1'b0;
      end
      OP_LUI: begin
        x_sel   = X_SEL_ZERO;
        y_sel   = Y_SEL_IMM;
        wen     = 1'b1;
        illegal = 1'b0;
      end
      OP_AUIPC: begin
        x_sel   = X_SEL_PC;
        y_sel   = Y_SEL_IMM;
        wen     = 1'b1;
        illegal = 1'b0;
      end
      OP_LOAD, OP_STORE: begin
        x_sel   = X_SEL_RS1;
        y_sel   = Y_SEL_IMM;
        wen     = (opcode == OP_LOAD);
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        // Comparison kind lives in funct3[2:1]; 01x has no branch encoding.
        case (funct3[2:1])
          2'b00: begin
            alu_op  = ALU_SUB;
            x_sel   = X_SEL_RS1;
            y_sel   = Y_SEL_RS2;
            illegal = 1'b0;
          end
          2'b10: begin
            alu_op  = ALU_SLT;
            x_sel   = X_SEL_RS1;
            y_sel   = Y_SEL_RS2;
            illegal = 1'b0;
          end
          2'b11: begin
            alu_op  = ALU_SLTU;
            x_sel   = X_SEL_RS1;
            y_sel   = Y_SEL_RS2;
            illegal = 1'b0;
          end
          default: begin
            illegal = 1'b1;
          end
        endcase
      end
      OP_JAL, OP_JALR: begin
        x_sel   = X_SEL_PC;
        y_sel   = Y_SEL_FOUR;
        wen     = 1'b1;
        illegal = 1'b0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: rv32i ID/EX issue stage feeding the `alu`.
//   in : decoded fields (opcode, funct3, funct7_5, rs1/rs2/rd addresses, imm, pc),
//        register-file data, EX/MEM and MEM/WB forwarding sources,
//        in_valid / flush from upstream, alu_ready from downstream.
//   out: in_ready, and the registered alu_valid, alu_op, alu_x, alu_y,
//        out_rd, out_wen, out_illegal.
// Single-entry pipeline register, 1-cycle latency, synchronous active-high rst.
// Build option: define ALU_ISSUE_FWD_EN to enable operand forwarding; without it
// the forwarding inputs are ignored and the hazard unit is expected to stall.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    pc,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic               exm_wen,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               wb_wen,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               alu_valid,
  input  logic               alu_ready,
  output logic [3:0]         alu_op,
  output logic [XLEN-1:0]    alu_x,
  output logic [XLEN-1:0]    alu_y,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen,
  output logic               out_illegal
);

  logic [3:0]         dec_op_s;
  x_sel_e             x_sel_s;
  y_sel_e             y_sel_s;
  logic               dec_wen_s;
  logic               dec_ill_s;
  logic [XLEN-1:0]    rs1_fwd_s;
  logic [XLEN-1:0]    rs2_fwd_s;
  logic [XLEN-1:0]    x_s;
  logic [XLEN-1:0]    y_s;
  logic               capture_s;

  logic               alu_valid_q, alu_valid_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [XLEN-1:0]    alu_x_q, alu_x_d;
  logic [XLEN-1:0]    alu_y_q, alu_y_d;
  logic [RADDR_W-1:0] out_rd_q, out_rd_d;
  logic               out_wen_q, out_wen_d;
  logic               out_illegal_q, out_illegal_d;

  alu_ctrl u_ctrl (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (dec_op_s),
    .x_sel    (x_sel_s),
    .y_sel    (y_sel_s),
    .wen      (dec_wen_s),
    .illegal  (dec_ill_s)
  );

`ifdef ALU_ISSUE_FWD_EN
  // Operand forwarding: the younger EX/MEM result beats MEM/WB; x0 never forwards.
  always_comb begin
    if (exm_wen && (exm_rd == rs1_addr) && (rs1_addr != {RADDR_W{1'b0}})) begin
      rs1_fwd_s = exm_data;
    end else if (wb_wen && (wb_rd == rs1_addr) && (rs1_addr != {RADDR_W{1'b0}})) begin
      rs1_fwd_s = wb_data;
    end else begin
      rs1_fwd_s = rs1_data;
    end
    if (exm_wen && (exm_rd == rs2_addr) && (rs2_addr != {RADDR_W{1'b0}})) begin
      rs2_fwd_s = exm_data;
    end else if (wb_wen && (wb_rd == rs2_addr) && (rs2_addr != {RADDR_W{1'b0}})) begin
      rs2_fwd_s = wb_data;
    end else begin
      rs2_fwd_s = rs2_data;
    end
  end
`else
  // Forwarding disabled: register-file data is used as read.
  always_comb begin
    rs1_fwd_s = rs1_data;
    rs2_fwd_s = rs2_data;
  end

  // Forwarding sources and source addresses have no consumer in this build.
  logic unused_fwd_s;
  assign unused_fwd_s = ^{exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data,
                          rs1_addr, rs2_addr};
`endif

  // Operand muxing after forwarding.
  always_comb begin
    case (x_sel_s)
      X_SEL_RS1: x_s = rs1_fwd_s;
      X_SEL_PC:  x_s = pc;
      default:   x_s = {XLEN{1'b0}};
    endcase
    case (y_sel_s)
      Y_SEL_RS2:  y_s = rs2_fwd_s;
      Y_SEL_IMM:  y_s = imm;
      Y_SEL_FOUR: y_s = XLEN'(32'd4);
      default:    y_s = {XLEN{1'b0}};
    endcase
  end

  // Accept whenever the register is empty or being drained this cycle.
  assign in_ready  = !alu_valid_q || alu_ready;
  assign capture_s = in_valid && in_ready && !flush;

  // Next-state for the pipeline register; payload holds unless capturing.
  always_comb begin
    alu_op_d      = alu_op_q;
    alu_x_d       = alu_x_q;
    alu_y_d       = alu_y_q;
    out_rd_d      = out_rd_q;
    out_wen_d     = out_wen_q;
    out_illegal_d = out_illegal_q;
    if (capture_s) begin
      alu_valid_d   = 1'b1;
      alu_op_d      = dec_op_s;
      alu_x_d       = x_s;
      alu_y_d       = y_s;
      out_rd_d      = rd_addr;
      out_wen_d     = dec_wen_s && (rd_addr != {RADDR_W{1'b0}});
      out_illegal_d = dec_ill_s;
    end else if (flush || alu_ready) begin
      alu_valid_d   = 1'b0;
    end else begin
      alu_valid_d   = alu_valid_q;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_q   <= 1'b0;
      alu_op_q      <= 4'h0;
      alu_x_q       <= {XLEN{1'b0}};
      alu_y_q       <= {XLEN{1'b0}};
      out_rd_q      <= {RADDR_W{1'b0}};
      out_wen_q     <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      alu_valid_q   <= alu_valid_d;
      alu_op_q      <= alu_op_d;
      alu_x_q       <= alu_x_d;
      alu_y_q       <= alu_y_d;
      out_rd_q      <= out_rd_d;
      out_wen_q     <= out_wen_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_op      = alu_op_q;
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue. Directed steps from the test
// plan followed by a randomized run scored against an instruction-level model.
// Expectations follow ALU_ISSUE_FWD_EN the same way the design build does.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] pc, rs1_data, rs2_data, imm, exm_data, wb_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exm_rd, wb_rd;
  logic        exm_wen, wb_wen;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_x, alu_y;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_x(alu_x), .alu_y(alu_y), .out_rd(out_rd), .out_wen(out_wen),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_valid"}, {31'd0, alu_valid}, 32'd1);
    chk({tag, "_op"},    {28'd0, alu_op}, {28'd0, e.op});
    chk({tag, "_x"},     alu_x, e.x);
    chk({tag, "_y"},     alu_y, e.y);
    chk({tag, "_rd"},    {27'd0, out_rd}, {27'd0, e.rd});
    chk({tag, "_wen"},   {31'd0, out_wen}, {31'd0, e.wen});
    chk({tag, "_ill"},   {31'd0, out_illegal}, {31'd0, e.ill});
  endtask

  // Register value the instruction would see once older in-flight writes are honoured.
  function automatic logic [31:0] reg_val(input logic [4:0] a, input logic [31:0] rf);
`ifdef ALU_ISSUE_FWD_EN
    if (a != 5'd0 && exm_wen && exm_rd == a) return exm_data;
    if (a != 5'd0 && wb_wen && wb_rd == a) return wb_data;
`endif
    return rf;
  endfunction

  // Instruction-level model of what the stage should present for the current inputs.
  function automatic exp_t model();
    logic [3:0]  arith [8] = '{4'h2, 4'h8, 4'h9, 4'ha, 4'h7, 4'hb, 4'h1, 4'h0};
    logic [31:0] r1, r2;
    exp_t e;
    r1 = reg_val(rs1_addr, rs1_data);
    r2 = reg_val(rs2_addr, rs2_data);
    e = '0;
    e.rd = rd_addr;
    e.op = 4'h2;
    case (opcode)
      7'h33: begin
        e.op = arith[funct3];
        if (funct7_5 && funct3 == 3'd0) e.op = 4'h6;
        if (funct7_5 && funct3 == 3'd5) e.op = 4'hc;
        e.x = r1; e.y = r2; e.wen = 1'b1;
      end
      7'h13: begin
        e.op = arith[funct3];
        if (funct7_5 && funct3 == 3'd5) e.op = 4'hc;
        e.x = r1; e.y = imm; e.wen = 1'b1;
      end
      7'h37: begin e.x = 32'd0; e.y = imm; e.wen = 1'b1; end
      7'h17: begin e.x = pc;    e.y = imm; e.wen = 1'b1; end
      7'h03: begin e.x = r1;    e.y = imm; e.wen = 1'b1; end
      7'h23: begin e.x = r1;    e.y = imm; end
      7'h63: begin
        e.x = r1; e.y = r2;
        if (funct3 <= 3'd1) e.op = 4'h6;
        else if (funct3 == 3'd4 || funct3 == 3'd5) e.op = 4'h9;
        else if (funct3 >= 3'd6) e.op = 4'ha;
        else e.ill = 1'b1;
      end
      7'h6f, 7'h67: begin e.x = pc; e.y = 32'd4; e.wen = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.op = 4'h2; e.x = 32'd0; e.y = 32'd0; e.wen = 1'b0;
    end
    if (rd_addr == 5'd0) e.wen = 1'b0;
    return e;
  endfunction

  task automatic set_inst(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                          input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] iv, input logic [31:0] pv);
    opcode = opc; funct3 = f3; funct7_5 = f75; rd_addr = rd;
    rs1_addr = a1; rs2_addr = a2; rs1_data = d1; rs2_data = d2; imm = iv; pc = pv;
  endtask

  logic [6:0]  opc_tab [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                7'h63, 7'h6f, 7'h67, 7'h7f};
  exp_t        e, ea, eb, held;
  logic        hv;
  logic [31:0] exp_x;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_ready = 1'b1;
    set_inst(7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exm_wen = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_x", alu_x, 32'd0);
    chk("rst_y", alu_y, 32'd0);
    chk("rst_wen", {31'd0, out_wen}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // R-type sub
    in_valid = 1'b1;
    set_inst(7'h33, 3'd0, 1'b1, 5'd5, 5'd1, 5'd2, 32'h0000ffff, 32'hffff0000, 32'd0, 32'd0);
    e = model(); tick();
    chk_out("sub", e);
    chk("sub_op_const", {28'd0, alu_op}, 32'h6);

    // OP-IMM srai / srli
    set_inst(7'h13, 3'd5, 1'b1, 5'd6, 5'd1, 5'd0, 32'h8000f000, 32'd0, 32'd4, 32'd0);
    e = model(); tick();
    chk_out("srai", e);
    chk("srai_op_const", {28'd0, alu_op}, 32'hc);
    funct7_5 = 1'b0;
    e = model(); tick();
    chk("srli_op_const", {28'd0, alu_op}, 32'hb);
    chk_out("srli", e);

    // AUIPC, JAL rd=1, JAL rd=0
    set_inst(7'h17, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00002000, 32'h00001000);
    tick();
    chk("auipc_x", alu_x, 32'h00001000);
    chk("auipc_y", alu_y, 32'h00002000);
    chk("auipc_op", {28'd0, alu_op}, 32'h2);
    set_inst(7'h6f, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00002000, 32'h00001000);
    tick();
    chk("jal_y", alu_y, 32'h00000004);
    chk("jal_wen", {31'd0, out_wen}, 32'd1);
    rd_addr = 5'd0;
    tick();
    chk("jal_rd0_wen", {31'd0, out_wen}, 32'd0);

    // Forwarding priority
    exm_wen = 1'b1; exm_rd = 5'd3; exm_data = 32'h11111111;
    wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'h22222222;
    set_inst(7'h13, 3'd0, 1'b0, 5'd4, 5'd3, 5'd0, 32'h33333333, 32'd0, 32'd1, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
    exp_x = 32'h11111111;
`else
    exp_x = 32'h33333333;
`endif
    tick();
    chk("fwd_exm", alu_x, exp_x);
    exm_wen = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    exp_x = 32'h22222222;
`else
    exp_x = 32'h33333333;
`endif
    tick();
    chk("fwd_wb", alu_x, exp_x);
    exm_wen = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0; rs1_addr = 5'd0;
    tick();
    chk("fwd_x0", alu_x, 32'h33333333);
    exm_wen = 1'b0; wb_wen = 1'b0;

    // Backpressure: A held for 3 cycles, then B follows with no bubble
    set_inst(7'h33, 3'd4, 1'b0, 5'd8, 5'd1, 5'd2, 32'hdeadbeef, 32'h0f0f0f0f, 32'd0, 32'd0);
    ea = model(); tick();
    set_inst(7'h03, 3'd2, 1'b0, 5'd9, 5'd1, 5'd0, 32'h00000100, 32'd0, 32'h00000010, 32'd0);
    eb = model();
    alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp_hold", ea);
      tick();
    end
    alu_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("bp_next", eb);

    // Flush with a live register and an incoming instruction
    flush = 1'b1;
    set_inst(7'h33, 3'd0, 1'b0, 5'd10, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 32'd0);
    tick();
    chk("flush_valid", {31'd0, alu_valid}, 32'd0);
    flush = 1'b0;

    // Illegal opcode and illegal branch funct3
    set_inst(7'h7f, 3'd0, 1'b0, 5'd11, 5'd1, 5'd2, 32'h55, 32'h66, 32'h77, 32'h88);
    tick();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_wen", {31'd0, out_wen}, 32'd0);
    chk("ill_x", alu_x, 32'd0);
    set_inst(7'h63, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'h55, 32'h66, 32'h77, 32'h88);
    e = model(); tick();
    chk_out("br_ill", e);

    // Reset mid-stream overrides capture
    set_inst(7'h33, 3'd6, 1'b0, 5'd12, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'd0, alu_valid}, 32'd0);
    chk("mrst_op", {28'd0, alu_op}, 32'd0);
    chk("mrst_x", alu_x, 32'd0);
    chk("mrst_rd", {27'd0, out_rd}, 32'd0);
    rst = 1'b0;
    hv = 1'b0;
    held = '0;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) opcode = 7'($urandom);
      else opcode = opc_tab[$urandom_range(0, 9)];
      funct3 = 3'($urandom_range(0, 7));
      funct7_5 = 1'($urandom_range(0, 1));
      rd_addr = 5'($urandom_range(0, 3));
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
      exm_wen = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3)); exm_data = $urandom;
      wb_wen = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      alu_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!hv || alu_ready)});
      e = model();
      if (in_valid && (!hv || alu_ready) && !flush) begin
        held = e; hv = 1'b1;
      end else if (flush || alu_ready) begin
        hv = 1'b0;
      end
      tick();
      chk("rnd_valid", {31'd0, alu_valid}, {31'd0, hv});
      if (hv) chk_out("rnd", held);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
